weight_stream_seq: RTL

Sequencer that streams the coefficients of one conv layer out of its synchronous weight ROM into the downstream coefficient stream. It drives the ROM's address and chip enable, absorbs the ROM's one-cycle read latency with a 2-entry skid buffer, honours `output_V_full_n` back-pressure without losing or repeating words, and repeats the full kernel a programmable number of passes. It replaces the HLS `weight_s_N` core inside each per-layer `weight_N` wrapper; the `rom` instance stays in the wrapper.

---
 rtl/weight_stream_seq_pkg.sv | 14 +
 rtl/weight_stream_seq_skid_fifo2.sv | 54 +++++
 rtl/weight_stream_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/weight_stream_seq_pkg.sv
// Shared types and constants for the weight ROM streaming sequencer.
package weight_stream_seq_pkg;

  // Width of the kernel pass counter; bounds the programmable pass count.
  localparam int PASS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/weight_stream_seq_skid_fifo2.sv
// Two-entry register FIFO that absorbs the ROM read latency under back-pressure.
// The producer never pushes into a full FIFO unless it also pops that cycle.
module skid_fifo2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;

  // Slot 0 is always the head; a pop shifts slot 1 forward.
  // NOTE: the storage slots are reset because the head drives a module output
  // that must read 0 out of reset; larger RAM-style buffers would not be reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments keep the shift (slot0 <= slot1) reading
      // the pre-edge value of slot1 regardless of statement order.
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/weight_stream_seq.sv
// Streams one conv layer's coefficients from its synchronous weight ROM into
// the coefficient FIFO, repeating the kernel N_PASSES times (0 = forever).
module weight_stream_seq
  import weight_stream_seq_pkg::*;
#(
  parameter int MEM_SIZE   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int N_PASSES   = 1,
  parameter int AW         = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ap_start,
  output logic                  ap_busy,
  output logic                  ap_done,
  output logic [AW-1:0]         weight_V_address0,
  output logic                  weight_V_ce0,
  input  logic [DATA_WIDTH-1:0] weight_V_q0,
  output logic [DATA_WIDTH-1:0] output_V_din,
  input  logic                  output_V_full_n,
  output logic                  output_V_write
);

  state_t              state;
  state_t              state_nxt;
  logic [AW-1:0]       addr;
  logic [PASS_W-1:0]   pass_cnt;
  logic                inflight;
  logic [1:0]          buf_count;
  logic [DATA_WIDTH-1:0] buf_head;
  logic                pop;
  logic [2:0]          occ;
  logic                ce;
  logic                addr_last;
  logic                last_issue;

  // Words held or in flight after this cycle's pop; a read may issue only if
  // its data is guaranteed a free slot when it returns.
  assign pop        = (buf_count != 2'd0) && output_V_full_n;
  assign occ        = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign ce         = (state == ST_RUN) && (occ < 3'd2);
  assign addr_last  = (addr == AW'(MEM_SIZE - 1));
  assign last_issue = ce && addr_last && (N_PASSES != 0) &&
                      (pass_cnt == PASS_W'(N_PASSES - 1));

  // State register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic: start is only honoured in IDLE.
  always_comb begin
    // NOTE: defaulting state_nxt before the case keeps this purely
    // combinational; a path that left it unassigned would infer a latch.
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (ap_start)    state_nxt = ST_RUN;
      ST_RUN:   if (last_issue)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (occ == 3'd0) state_nxt = ST_DONE;
      ST_DONE:                   state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // Address and pass counters: cleared on start, advanced only by issued reads.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      addr     <= '0;
      pass_cnt <= '0;
    end else if (state == ST_IDLE && ap_start) begin
      addr     <= '0;
      pass_cnt <= '0;
    end else if (ce) begin
      if (addr_last) begin
        addr     <= '0;
        pass_cnt <= pass_cnt + PASS_W'(1);
      end else begin
        addr <= addr + AW'(1);
      end
    end
  end

  // A read issued this cycle returns data on weight_V_q0 next cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) inflight <= 1'b0;
    else           inflight <= ce;
  end

  skid_fifo2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .push      (inflight),
    .push_data (weight_V_q0),
    .pop       (pop),
    .count     (buf_count),
    .head      (buf_head)
  );

  assign weight_V_address0 = addr;
  assign weight_V_ce0      = ce;
  assign output_V_write    = pop;
  assign output_V_din      = buf_head;
  assign ap_busy           = (state != ST_IDLE);
  assign ap_done           = (state == ST_DONE);

endmodule
